hex7seg_scan: RTL and testbench

//  Parametrised time-multiplexed hex display driver for DIGITS common-select 7-seg digits (EGO1 class boards).

---
 rtl/hex7seg_pkg.sv | 18 +
 rtl/hex7seg_dec.sv | 11 +
 rtl/hex7seg_scan.sv | 109 ++++++++++
 tb/tb_hex7seg_scan.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/hex7seg_pkg.sv
// rtl/hex7seg_pkg.sv - segment glyph table and nibble decode helper for hex7seg_scan
package hex7seg_pkg;

  localparam logic [6:0] SEG_OFF = 7'b0000000;

  // bit6=a .. bit0=g, active-high
  localparam logic [6:0] SEG_GLYPH [16] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
    7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
    7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
    7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
  };

  function automatic logic [6:0] seg_decode(input logic [3:0] nibble);
    return SEG_GLYPH[nibble];
  endfunction

endpackage

// File: rtl/hex7seg_dec.sv
// rtl/hex7seg_dec.sv - combinational nibble to a..g segment decoder
module hex7seg_dec
  import hex7seg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = seg_decode(nibble);

endmodule

// File: rtl/hex7seg_scan.sv
// rtl/hex7seg_scan.sv - time-multiplexed hex display scanner with frame-latched shadow inputs
// Optional brightness PWM on the digit selects when HEX7SEG_SCAN_DIM_EN is defined.
module hex7seg_scan
  import hex7seg_pkg::*;
#(
  parameter int DIGITS = 4,
  parameter int DIV    = 100000
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic [4*DIGITS-1:0]   x,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic [DIGITS-1:0]     blank,
`ifdef HEX7SEG_SCAN_DIM_EN
  input  logic [3:0]            duty,
`endif
  output logic [6:0]            a_to_g,
  output logic                  dp,
  output logic [DIGITS-1:0]     an,
  output logic                  frame_tick
);

  localparam int CW = $clog2(DIV);
  localparam int SW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
  localparam logic [SW-1:0] SEL_LAST = SW'(DIGITS - 1);

  logic [CW-1:0]         cnt;
  logic [SW-1:0]         sel;
  logic [4*DIGITS-1:0]   shadow_x;
  logic [DIGITS-1:0]     shadow_dp;
  logic [DIGITS-1:0]     shadow_blank;
  logic                  fresh;
  logic                  slot_end;
  logic                  latch;
  logic                  gate_off;
  logic [3:0]            nib;
  logic [6:0]            seg;
  logic [DIGITS-1:0]     onehot;
  logic                  blank_sel;
  logic                  dp_sel;

  assign slot_end = (cnt == CNT_LAST);
  // fresh forces a latch on the first edge after reset so the display never shows stale data for a whole frame
  assign latch    = fresh | (slot_end && sel == SEL_LAST);

  always_comb begin
    nib       = 4'h0;
    onehot    = '0;
    blank_sel = 1'b0;
    dp_sel    = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (sel == SW'(i)) begin
        nib       = shadow_x[4*i +: 4];
        onehot[i] = 1'b1;
        blank_sel = shadow_blank[i];
        dp_sel    = shadow_dp[i];
      end
    end
  end

  hex7seg_dec u_dec (
    .nibble (nib),
    .seg    (seg)
  );

`ifdef HEX7SEG_SCAN_DIM_EN
  logic [3:0] pwm;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) pwm <= 4'h0;
    else     pwm <= pwm + 4'h1;
  end

  assign gate_off = (pwm > duty);
`else
  assign gate_off = 1'b0;
`endif

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      cnt          <= '0;
      sel          <= '0;
      fresh        <= 1'b1;
      shadow_x     <= '0;
      shadow_dp    <= '0;
      shadow_blank <= '0;
      frame_tick   <= 1'b0;
      an           <= '0;
      a_to_g       <= SEG_OFF;
      dp           <= 1'b0;
    end else begin
      cnt        <= slot_end ? '0 : cnt + 1'b1;
      fresh      <= 1'b0;
      frame_tick <= latch;
      if (slot_end) sel <= (sel == SEL_LAST) ? '0 : sel + 1'b1;
      if (latch) begin
        shadow_x     <= x;
        shadow_dp    <= dp_in;
        shadow_blank <= blank;
      end
      // dimming only gates the selects; segments stay steady through the slot
      an     <= (blank_sel || gate_off) ? '0 : onehot;
      a_to_g <= blank_sel ? SEG_OFF : seg;
      dp     <= !blank_sel && dp_sel;
    end
  end

endmodule

// File: tb/tb_hex7seg_scan.sv
// tb/tb_hex7seg_scan.sv - directed self-checking bench for hex7seg_scan (DIGITS=4, DIV=4)
module tb_hex7seg_scan;

  localparam logic [6:0] G0 = 7'b1111110;
  localparam logic [6:0] G1 = 7'b0110000;
  localparam logic [6:0] G2 = 7'b1101101;
  localparam logic [6:0] GA = 7'b1110111;
  localparam logic [6:0] GF = 7'b1000111;

  logic        clk = 1'b0;
  logic        clr;
  logic [15:0] x;
  logic [3:0]  dp_in;
  logic [3:0]  blank;
  logic [6:0]  a_to_g;
  logic        dp;
  logic [3:0]  an;
  logic        frame_tick;

  int checks = 0;
  int errors = 0;
  int k = 0;

`ifdef HEX7SEG_SCAN_DIM_EN
  logic [3:0] duty;
  logic [3:0] duty_dim;
  logic [6:0] a_to_g_dim;
  logic       dp_dim;
  logic [3:0] an_dim;
  logic       frame_tick_dim;

  hex7seg_scan #(.DIGITS(4), .DIV(16)) u_dim (
    .clk        (clk),
    .clr        (clr),
    .x          (x),
    .dp_in      (dp_in),
    .blank      (blank),
    .duty       (duty_dim),
    .a_to_g     (a_to_g_dim),
    .dp         (dp_dim),
    .an         (an_dim),
    .frame_tick (frame_tick_dim)
  );
`endif

  hex7seg_scan #(.DIGITS(4), .DIV(4)) dut (
    .clk        (clk),
    .clr        (clr),
    .x          (x),
    .dp_in      (dp_in),
    .blank      (blank),
`ifdef HEX7SEG_SCAN_DIM_EN
    .duty       (duty),
`endif
    .a_to_g     (a_to_g),
    .dp         (dp),
    .an         (an),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    k++;
  endtask

  task automatic do_reset();
    clr = 1'b1;
    @(negedge clk);
    @(negedge clk);
    clr = 1'b0;
    k = 0;
  endtask

  task automatic test_reset();
    clr = 1'b1; x = 16'h12AF; dp_in = 4'b1111; blank = 4'b0000;
    @(negedge clk);
    @(negedge clk);
    checks++; if (an !== 4'b0000) begin errors++; $display("FAIL reset_an got %b exp 0000", an); end
    checks++; if (a_to_g !== 7'b0) begin errors++; $display("FAIL reset_seg got %b exp 0000000", a_to_g); end
    checks++; if (dp !== 1'b0) begin errors++; $display("FAIL reset_dp got %b exp 0", dp); end
    checks++; if (frame_tick !== 1'b0) begin errors++; $display("FAIL reset_tick got %b exp 0", frame_tick); end
    clr = 1'b0; k = 0;
    step();
    checks++; if (an !== 4'b0001) begin errors++; $display("FAIL release_an got %b exp 0001", an); end
    checks++; if (frame_tick !== 1'b1) begin errors++; $display("FAIL release_tick got %b exp 1", frame_tick); end
    while (k < 6) step();
    checks++; if (an !== 4'b0010 || dp !== 1'b1) begin errors++; $display("FAIL pre_clr got an=%b dp=%b exp an=0010 dp=1", an, dp); end
    clr = 1'b1;
    #1;
    checks++; if (an !== 4'b0000) begin errors++; $display("FAIL midclr_an got %b exp 0000", an); end
    checks++; if (a_to_g !== 7'b0) begin errors++; $display("FAIL midclr_seg got %b exp 0000000", a_to_g); end
    checks++; if (dp !== 1'b0) begin errors++; $display("FAIL midclr_dp got %b exp 0", dp); end
    @(negedge clk);
    clr = 1'b0; k = 0;
    step();
    checks++; if (an !== 4'b0001 || frame_tick !== 1'b1) begin errors++; $display("FAIL rerelease got an=%b tick=%b exp an=0001 tick=1", an, frame_tick); end
    while (k < 4) step();
    checks++; if (an !== 4'b0001) begin errors++; $display("FAIL rerelease_k4 got %b exp 0001", an); end
    step();
    checks++; if (an !== 4'b0010) begin errors++; $display("FAIL rerelease_k5 got %b exp 0010", an); end
  endtask

  task automatic test_scan();
    logic [6:0] exp_seg [4];
    int d;
    exp_seg = '{GF, GA, G2, G1};
    x = 16'h12AF; dp_in = 4'b0000; blank = 4'b0000;
    do_reset();
    while (k < 48) begin
      step();
      d = ((k - 1) / 4) % 4;
      checks++; if (an !== 4'(1 << d)) begin errors++; $display("FAIL scan_an k=%0d got %b exp %b", k, an, 4'(1 << d)); end
      checks++; if (frame_tick !== (k == 1 || k % 16 == 0)) begin errors++; $display("FAIL scan_tick k=%0d got %b", k, frame_tick); end
      if (k >= 2) begin
        checks++; if (a_to_g !== exp_seg[d]) begin errors++; $display("FAIL scan_seg k=%0d got %b exp %b", k, a_to_g, exp_seg[d]); end
      end
    end
  endtask

  task automatic test_midframe();
    logic [6:0] exp_seg [4];
    int d;
    exp_seg = '{GF, GA, G2, G1};
    x = 16'h12AF; dp_in = 4'b0000; blank = 4'b0000;
    do_reset();
    while (k < 40) begin
      step();
      d = ((k - 1) / 4) % 4;
      if (k >= 23 && k <= 32) begin
        checks++; if (a_to_g !== exp_seg[d]) begin errors++; $display("FAIL midframe_old k=%0d got %b exp %b", k, a_to_g, exp_seg[d]); end
      end
      if (k >= 33) begin
        checks++; if (a_to_g !== G0 || an !== 4'(1 << d)) begin errors++; $display("FAIL midframe_new k=%0d got seg=%b an=%b exp seg=%b", k, a_to_g, an, G0); end
      end
      if (k == 22) x = 16'h0000;
    end
  endtask

  task automatic test_blank();
    logic [6:0] exp_seg [4];
    int d;
    exp_seg = '{GF, GA, G2, G1};
    x = 16'h12AF; dp_in = 4'b0000; blank = 4'b0100;
    do_reset();
    while (k < 48) begin
      step();
      d = ((k - 1) / 4) % 4;
      if (k >= 17) begin
        checks++;
        if (d == 2) begin
          if (an !== 4'b0000 || a_to_g !== 7'b0) begin errors++; $display("FAIL blank_dark k=%0d got an=%b seg=%b exp an=0000 seg=0000000", k, an, a_to_g); end
        end else begin
          if (an !== 4'(1 << d) || a_to_g !== exp_seg[d]) begin errors++; $display("FAIL blank_lit k=%0d got an=%b seg=%b exp an=%b seg=%b", k, an, a_to_g, 4'(1 << d), exp_seg[d]); end
        end
        checks++; if (frame_tick !== (k % 16 == 0)) begin errors++; $display("FAIL blank_tick k=%0d got %b", k, frame_tick); end
      end
    end
    blank = 4'b0000;
  endtask

  task automatic test_dp();
    int d;
    x = 16'h12AF; dp_in = 4'b0001; blank = 4'b0000;
    do_reset();
    while (k < 32) begin
      step();
      d = ((k - 1) / 4) % 4;
      if (k >= 17) begin
        checks++; if (dp !== (d == 0)) begin errors++; $display("FAIL dp k=%0d got %b exp %b", k, dp, (d == 0)); end
      end
    end
  endtask

`ifdef HEX7SEG_SCAN_DIM_EN
  task automatic test_dim();
    int on_cnt;
    x = 16'h12AF; dp_in = 4'b0000; blank = 4'b0000;
    duty_dim = 4'd3;
    do_reset();
    on_cnt = 0;
    while (k < 32) begin
      step();
      if (k >= 17 && an_dim !== 4'b0000) begin
        on_cnt++;
        checks++; if (an_dim !== 4'b0010) begin errors++; $display("FAIL dim_an k=%0d got %b exp 0010", k, an_dim); end
      end
    end
    checks++; if (on_cnt != 4) begin errors++; $display("FAIL dim_duty3 got %0d exp 4", on_cnt); end
    duty_dim = 4'd15;
    on_cnt = 0;
    while (k < 48) begin
      step();
      if (k >= 33 && an_dim === 4'b0100) on_cnt++;
    end
    checks++; if (on_cnt != 16) begin errors++; $display("FAIL dim_duty15 got %0d exp 16", on_cnt); end
  endtask
`endif

  initial begin
`ifdef HEX7SEG_SCAN_DIM_EN
    duty = 4'd15;
    duty_dim = 4'd15;
`endif
    test_reset();
    test_scan();
    test_midframe();
    test_blank();
    test_dp();
`ifdef HEX7SEG_SCAN_DIM_EN
    test_dim();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
